// File: rtl/khu_sensor_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : khu_sensor_pkg
//  Description : Shared constants for the KHU sensor pad-input path:
//                channel indices, default widths and idle levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package khu_sensor_pkg;

   // Channel index of each pad input on the conditioned bus
   localparam int CH_MISO = 0;   // ADS1292_MISO
   localparam int CH_DRDY = 1;   // ADS1292_DRDY
   localparam int CH_RXD  = 2;   // UART_RXD
   localparam int CH_SCL  = 3;   // MPR121_SCL_IN
   localparam int CH_SDA  = 4;   // MPR121_SDA_IN

   localparam int NUM_CH_DEF   = 5;
   localparam int FILT_LEN_DEF = 4;
   localparam int FILT_LEN_MAX = 15;

   // MISO idles low; DRDY, UART RX and the I2C lines idle high
   localparam logic [NUM_CH_DEF-1:0] IDLE_VAL_DEF = 5'b11110;

   // Width of a counter that must hold the values 0..filt_len
   function automatic int cnt_width(input int filt_len);
      return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
   endfunction

endpackage : khu_sensor_pkg
`default_nettype wire

// File: rtl/khu_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : khu_sync_filter
//  Description : One pad-input channel: two-flop synchronizer, stability
//                counter, registered edge pulses and sticky glitch flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module khu_sync_filter
   import khu_sensor_pkg::*;
#(
   parameter int   FILT_LEN = FILT_LEN_DEF,   // legal range 1..15
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_in,
   input  logic filt_en,
   input  logic glitch_clr,
   output logic level,
   output logic rise,
   output logic fall,
   output logic glitch
);

   localparam int               CNT_W    = cnt_width(FILT_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             accept;
   logic             glitch_set;

   // Decide whether the synchronized level is accepted this cycle, and
   // whether a candidate change just collapsed before being accepted
   always_comb begin
      differ     = (sync2 != level);
      accept     = differ && (!filt_en || (cnt == CNT_LAST));
      glitch_set = filt_en && !differ && (cnt != '0);
   end

   // Two-flop synchronizer; the only consumer of the raw pad level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= IDLE_BIT;
         sync2 <= IDLE_BIT;
      end else begin
         sync1 <= pad_in;
         sync2 <= sync1;
      end
   end

   // Stability counter: advances while a new level persists, cleared on
   // acceptance, on return to the current level, or whenever bypassed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!filt_en || !differ || accept) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Filtered level with one-cycle edge pulses aligned to the new level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= IDLE_BIT;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= accept &&  sync2;
         fall <= accept && !sync2;
         if (accept) begin
            level <= sync2;
         end
      end
   end

   // Sticky glitch flag; a new glitch outranks a coincident clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch <= 1'b0;
      end else begin
         glitch <= glitch_set || (glitch && !glitch_clr);
      end
   end

endmodule : khu_sync_filter
`default_nettype wire

// File: rtl/khu_pad_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : khu_pad_input_cond
//  Description : Conditions raw pad-cell levels (synchronize, debounce,
//                edge detect, glitch report) between khu_sensor_pad and
//                khu_sensor_top. Contains no pad cells.
//  Revision    : 1.0 - initial release
// ============================================================================
module khu_pad_input_cond
   import khu_sensor_pkg::*;
#(
   parameter int                NUM_CH   = NUM_CH_DEF,
   parameter int                FILT_LEN = FILT_LEN_DEF,
   parameter logic [NUM_CH-1:0] IDLE_VAL = NUM_CH'(IDLE_VAL_DEF)
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic [NUM_CH-1:0] i_PAD_IN,
   input  logic [NUM_CH-1:0] i_FILT_EN,
   input  logic              i_GLITCH_CLR,
   output logic [NUM_CH-1:0] o_LEVEL,
   output logic [NUM_CH-1:0] o_RISE,
   output logic [NUM_CH-1:0] o_FALL,
   output logic [NUM_CH-1:0] o_GLITCH
);

   // Channels are fully independent; one conditioner per pad input
   generate
      for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
         khu_sync_filter #(
            .FILT_LEN (FILT_LEN),
            .IDLE_BIT (IDLE_VAL[ch])
         ) u_sync_filter (
            .clk        (i_CLK),
            .rst        (i_RST),
            .pad_in     (i_PAD_IN[ch]),
            .filt_en    (i_FILT_EN[ch]),
            .glitch_clr (i_GLITCH_CLR),
            .level      (o_LEVEL[ch]),
            .rise       (o_RISE[ch]),
            .fall       (o_FALL[ch]),
            .glitch     (o_GLITCH[ch])
         );
      end
   endgenerate

endmodule : khu_pad_input_cond
`default_nettype wire

// File: tb/tb_khu_pad_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_khu_pad_input_cond
//  Description : Directed self-checking bench for khu_pad_input_cond
//                (FILT_LEN=4, IDLE_VAL=5'b11110).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_khu_pad_input_cond;

   logic       clk;
   logic       rst;
   logic [4:0] pad_in;
   logic [4:0] filt_en;
   logic       glitch_clr;
   logic [4:0] level;
   logic [4:0] rise;
   logic [4:0] fall;
   logic [4:0] glitch;

   int checks = 0;
   int errors = 0;

   khu_pad_input_cond #(
      .NUM_CH   (5),
      .FILT_LEN (4),
      .IDLE_VAL (5'b11110)
   ) dut (
      .i_CLK        (clk),
      .i_RST        (rst),
      .i_PAD_IN     (pad_in),
      .i_FILT_EN    (filt_en),
      .i_GLITCH_CLR (glitch_clr),
      .o_LEVEL      (level),
      .o_RISE       (rise),
      .o_FALL       (fall),
      .o_GLITCH     (glitch)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [4:0] e_lvl, input logic [4:0] e_rise,
                            input logic [4:0] e_fall, input logic [4:0] e_gl);
      check({tag, ".level"},  level,  e_lvl);
      check({tag, ".rise"},   rise,   e_rise);
      check({tag, ".fall"},   fall,   e_fall);
      check({tag, ".glitch"}, glitch, e_gl);
   endtask

   // One rising edge, then return to the falling edge for drive/sample
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      pad_in     = 5'b11110;
      filt_en    = 5'b11111;
      glitch_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_all("reset", 5'b11110, 5'b0, 5'b0, 5'b0);

      // Reset release at idle: quiet for 20 cycles
      rst = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         check_all($sformatf("idle_t%0d", t), 5'b11110, 5'b0, 5'b0, 5'b0);
      end

      // ch2 1->0 held: accepted on the 6th edge counting the sync1 sample
      pad_in = 5'b11010;
      for (int t = 1; t <= 5; t++) begin
         tick();
         check_all($sformatf("ch2fall_t%0d", t), 5'b11110, 5'b0, 5'b0, 5'b0);
      end
      tick();
      check_all("ch2fall_t6", 5'b11010, 5'b0, 5'b00100, 5'b0);
      tick();
      check_all("ch2fall_t7", 5'b11010, 5'b0, 5'b0, 5'b0);
      pad_in = 5'b11110;
      repeat (8) tick();
      check_all("ch2restore", 5'b11110, 5'b0, 5'b0, 5'b0);

      // ch1 low for 3 cycles: rejected, glitch flagged on the 6th edge
      pad_in = 5'b11100;
      repeat (3) tick();
      pad_in = 5'b11110;
      for (int t = 4; t <= 8; t++) begin
         tick();
         check_all($sformatf("ch1glitch_t%0d", t), 5'b11110, 5'b0, 5'b0,
                   (t >= 6) ? 5'b00010 : 5'b00000);
      end
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      check("ch1glitch_clr", glitch, 5'b00000);

      // ch0 bypass: 3-edge latency, single-cycle pulse passes through
      filt_en = 5'b11110;
      repeat (2) tick();
      pad_in = 5'b11111;
      tick();
      check_all("ch0byp_t1", 5'b11110, 5'b0, 5'b0, 5'b0);
      tick();
      check_all("ch0byp_t2", 5'b11110, 5'b0, 5'b0, 5'b0);
      tick();
      check_all("ch0byp_t3", 5'b11111, 5'b00001, 5'b0, 5'b0);
      tick();
      check_all("ch0byp_t4", 5'b11111, 5'b0, 5'b0, 5'b0);
      pad_in = 5'b11110;
      tick();
      pad_in = 5'b11111;
      tick();
      check_all("ch0pulse_t2", 5'b11111, 5'b0, 5'b0, 5'b0);
      tick();
      check_all("ch0pulse_t3", 5'b11110, 5'b0, 5'b00001, 5'b0);
      tick();
      check_all("ch0pulse_t4", 5'b11111, 5'b00001, 5'b0, 5'b0);
      tick();
      check_all("ch0pulse_t5", 5'b11111, 5'b0, 5'b0, 5'b0);

      // Set ch1 glitch, then ch4 glitch coinciding with the clear pulse
      pad_in = 5'b11101;
      repeat (3) tick();
      pad_in = 5'b11111;
      repeat (5) tick();
      check("pre_ch4_glitch", glitch, 5'b00010);
      pad_in = 5'b01111;
      repeat (2) tick();
      pad_in = 5'b11111;
      repeat (2) tick();
      check("ch4_before_set", glitch, 5'b00010);
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      check_all("ch4_set_wins", 5'b11111, 5'b0, 5'b0, 5'b10000);
      tick();
      check("ch4_sticky", glitch, 5'b10000);

      // ch3 1->0, reset asserted at count 2: async load, count discarded
      pad_in = 5'b10111;
      repeat (4) tick();
      check("ch3_count2", level, 5'b11111);
      rst = 1'b1;
      #1;
      check_all("ch3_async_rst", 5'b11110, 5'b0, 5'b0, 5'b0);
      @(negedge clk);
      rst = 1'b0;
      // After release: ch0 (bypass) rises at edge 3, ch3 falls at edge 6
      tick();
      check_all("post_rst_t1", 5'b11110, 5'b0, 5'b0, 5'b0);
      tick();
      check_all("post_rst_t2", 5'b11110, 5'b0, 5'b0, 5'b0);
      tick();
      check_all("post_rst_t3", 5'b11111, 5'b00001, 5'b0, 5'b0);
      tick();
      check_all("post_rst_t4", 5'b11111, 5'b0, 5'b0, 5'b0);
      tick();
      check_all("post_rst_t5", 5'b11111, 5'b0, 5'b0, 5'b0);
      tick();
      check_all("post_rst_t6", 5'b10111, 5'b0, 5'b01000, 5'b0);
      tick();
      check_all("post_rst_t7", 5'b10111, 5'b0, 5'b0, 5'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_khu_pad_input_cond
`default_nettype wire

// File: doc/khu_pad_input_cond.md
KHU_PAD_INPUT_COND -- requirements
Module: khu_pad_input_cond

Interface
REQ-001 SHALL provide parameter NUM_CH, default 5, number of pad-input channels (ch0 ADS1292_MISO, ch1 ADS1292_DRDY, ch2 UART_RXD, ch3 MPR121_SCL_IN, ch4 MPR121_SDA_IN).
REQ-002 SHALL provide parameter FILT_LEN, default 4, consecutive stable cycles required to accept a new level; legal range 1..15.
REQ-003 SHALL provide parameter IDLE_VAL, default 5'b11110, per-channel reset/idle level.
REQ-004 SHALL provide port i_CLK  in  1  single clock for all logic.
REQ-005 SHALL provide port i_RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port i_PAD_IN  in  NUM_CH  raw asynchronous levels from the pad-cell Y outputs.
REQ-007 SHALL provide port i_FILT_EN  in  NUM_CH  per-channel filter enable; 0 = bypass.
REQ-008 SHALL provide port i_GLITCH_CLR  in  1  single-cycle clear of all glitch flags.
REQ-009 SHALL provide port o_LEVEL  out  NUM_CH  synchronized, filtered level delivered to khu_sensor_top.
REQ-010 SHALL provide port o_RISE  out  NUM_CH  one-cycle pulse on each accepted 0->1 change of o_LEVEL.
REQ-011 SHALL provide port o_FALL  out  NUM_CH  one-cycle pulse on each accepted 1->0 change of o_LEVEL.
REQ-012 SHALL provide port o_GLITCH  out  NUM_CH  sticky flag: a rejected pulse was seen on the channel.

Function
REQ-013 Each channel SHALL pass i_PAD_IN through a two-flop synchronizer (sync1, sync2); no other logic reads i_PAD_IN.
REQ-014 Each filtered channel SHALL hold a counter of width ceil(log2(FILT_LEN+1)); counter increments each cycle sync2 != o_LEVEL.
REQ-015 When sync2 != o_LEVEL and counter == FILT_LEN-1, o_LEVEL SHALL take sync2 on that edge and counter SHALL clear to 0.
REQ-016 When sync2 == o_LEVEL, counter SHALL clear to 0; if counter was nonzero, o_GLITCH for that channel SHALL set.
REQ-017 Filtered latency: pad change held stable SHALL reach o_LEVEL exactly 2+FILT_LEN rising edges after it is first sampled by sync1.
REQ-018 Pulses shorter than FILT_LEN cycles at sync2 SHALL never change o_LEVEL.
REQ-019 Bypass (i_FILT_EN=0): o_LEVEL SHALL register sync2 every cycle (latency 3 edges); counter held at 0; o_GLITCH not set.
REQ-020 Toggling i_FILT_EN mid-count SHALL clear that channel's counter on the same edge; o_LEVEL is not forced.
REQ-021 o_RISE/o_FALL SHALL be registered and asserted in the cycle o_LEVEL shows its new value, exactly one cycle long; never both in one cycle.
REQ-022 i_GLITCH_CLR SHALL clear all o_GLITCH bits; if set and clear coincide on one channel, set SHALL win.
REQ-023 Channels SHALL be fully independent; counters never wrap (saturating at the accept point by REQ-015).

Reset
REQ-024 On i_RST=1, sync1, sync2 and o_LEVEL SHALL load IDLE_VAL, counters 0, o_RISE/o_FALL/o_GLITCH 0, asynchronously.
REQ-025 First cycle after reset release SHALL generate no edge pulse, even if the pad differs from IDLE_VAL; the change is then qualified per REQ-015.
REQ-026 Reset asserted mid-count SHALL discard the pending count with no pulse emitted.

Structure
REQ-027 Channel index constants (CH_MISO=0 .. CH_SDA=4), NUM_CH default and IDLE_VAL default SHALL live in shared package khu_sensor_pkg.
REQ-028 One sub-module khu_sync_filter (single channel: synchronizer, counter, edge and glitch logic) SHALL be instantiated NUM_CH times by generate.
REQ-029 Block SHALL sit between khu_sensor_pad input cells and khu_sensor_top; it contains no pad cells.

Verification (FILT_LEN=4, all i_FILT_EN=1 unless stated)
REQ-030 Reset release with i_PAD_IN=5'b11110 -> o_LEVEL=5'b11110, no pulses, no glitches for 20 cycles.
REQ-031 ch2 pad 1->0 held -> o_LEVEL[2]=0 and o_FALL[2]=1 for one cycle exactly 6 edges after first sync1 sample.
REQ-032 ch1 pad low for 3 cycles then high -> o_LEVEL[1] stays 1, no pulses, o_GLITCH[1]=1; i_GLITCH_CLR pulse -> 0.
REQ-033 ch0 with i_FILT_EN[0]=0, pad 0->1 -> o_LEVEL[0]=1 and o_RISE[0] after 3 edges; a 1-cycle pad pulse propagates unfiltered.
REQ-034 Glitch on ch4 in the same cycle as i_GLITCH_CLR -> o_GLITCH[4]=1 afterwards; other bits cleared.
REQ-035 i_RST asserted at count 2 of a ch3 transition -> o_LEVEL[3]=1 immediately, counter 0, no o_FALL[3] emitted.
